// File: rtl/relu_pool_if.sv
// Handshake bundle between the bias-add stage, the ReLU/max-pool stage and the
// feature-map writeback.
//   in_data   : array_size signed lanes, lane i at [(i+1)*data_size-1 : i*data_size]
//   in_done   : per-lane done flags; a beat is valid only when all are set
//   in_ready  : stage can accept a beat this cycle
//   flush     : close the current pooling window early
//   out_data  : pooled lanes, same packing as in_data
//   out_valid : out_data holds an unconsumed result
//   out_ready : downstream accepts out_data
//   beat_cnt  : beats already collected in the current window
//   lane_err  : sticky flag, set by a partial done vector
// Modports: master drives the inputs of the stage, slave is the stage itself.
interface relu_pool_if #(
  parameter int unsigned data_size  = 16,
  parameter int unsigned array_size = 9
);
  logic [array_size*data_size-1:0] in_data;
  logic [array_size-1:0]           in_done;
  logic                            in_ready;
  logic                            flush;
  logic [array_size*data_size-1:0] out_data;
  logic                            out_valid;
  logic                            out_ready;
  logic [3:0]                      beat_cnt;
  logic                            lane_err;

  modport master (
    output in_data, in_done, flush, out_ready,
    input  in_ready, out_data, out_valid, beat_cnt, lane_err
  );

  modport slave (
    input  in_data, in_done, flush, out_ready,
    output in_ready, out_data, out_valid, beat_cnt, lane_err
  );
endinterface

// File: rtl/relu_pool_stage.sv
// ReLU + max-pool stage. Each accepted beat is rectified per lane and folded
// into a per-lane running maximum; after pool_len beats (or an early flush) the
// per-lane maxima are loaded into a registered valid/ready output slot.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : relu_pool_if.slave (input beats, flush, pooled output, status)
// Optional feature: define RELU_CLIP_EN to bound the ReLU output at clip_max
// (bounded ReLU for 8-bit requantization downstream). Without it clip_max is
// unused and no clip logic is built.
module relu_pool_stage #(
  parameter int unsigned                 data_size  = 16,
  parameter int unsigned                 array_size = 9,
  parameter int unsigned                 pool_len   = 4,
  parameter logic signed [data_size-1:0] clip_max   = 16'sd255
) (
  input logic        clk,
  input logic        reset,
  relu_pool_if.slave bus
);

  localparam logic [3:0] last_beat = 4'(pool_len - 1);

  if (pool_len < 2 || pool_len > 16) begin : g_bad_pool_len
    $error("relu_pool_stage: pool_len must be in 2..16");
  end
  if (clip_max < 0) begin : g_bad_clip_max
    $error("relu_pool_stage: clip_max must be non-negative");
  end

  logic signed [data_size-1:0] acc_q [array_size];
  logic [array_size*data_size-1:0] out_data_q;
  logic                            out_valid_q;
  logic [3:0]                      beat_cnt_q;
  logic                            lane_err_q;
  logic                            flush_pend_q;

  logic signed [data_size-1:0] lane_in  [array_size];
  logic signed [data_size-1:0] relu_val [array_size];
  logic signed [data_size-1:0] merged   [array_size];
  logic [array_size*data_size-1:0] merged_flat;

  logic in_valid, in_ready, accept, slot_free, flush_req;
  logic have_data, is_final, emit, partial;

  always_comb begin
    in_valid  = &bus.in_done;
    partial   = (|bus.in_done) && !in_valid;
    // Only the window-closing beat can stall, and only on an occupied,
    // undrained output slot.
    in_ready  = (beat_cnt_q != last_beat) || !out_valid_q || bus.out_ready;
    accept    = in_valid && in_ready;
    slot_free = !out_valid_q || bus.out_ready;
    flush_req = bus.flush || flush_pend_q;
    have_data = (beat_cnt_q != 4'd0) || accept;
    is_final  = accept && (beat_cnt_q == last_beat);
    // A flushed window emits only when it holds something; the beat accepted
    // in the same cycle is folded in via merged.
    emit      = slot_free && (is_final || (flush_req && have_data));

    merged_flat = '0;
    for (int i = 0; i < array_size; i++) begin
      lane_in[i] = $signed(bus.in_data[i*data_size +: data_size]);
`ifdef RELU_CLIP_EN
      if (lane_in[i][data_size-1]) begin
        relu_val[i] = '0;
      end else if (lane_in[i] > clip_max) begin
        relu_val[i] = clip_max;
      end else begin
        relu_val[i] = lane_in[i];
      end
`else
      relu_val[i] = lane_in[i][data_size-1] ? '0 : lane_in[i];
`endif
      // Accumulators and ReLU outputs are both non-negative, so a rejected
      // beat simply leaves the accumulator value through.
      merged[i] = (accept && (relu_val[i] > acc_q[i])) ? relu_val[i] : acc_q[i];
      merged_flat[i*data_size +: data_size] = merged[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < array_size; i++) acc_q[i] <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      beat_cnt_q   <= 4'd0;
      lane_err_q   <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      if (partial) lane_err_q <= 1'b1;
      if (emit) begin
        // Load wins over a simultaneous transfer, keeping out_valid high.
        out_data_q   <= merged_flat;
        out_valid_q  <= 1'b1;
        for (int i = 0; i < array_size; i++) acc_q[i] <= '0;
        beat_cnt_q   <= 4'd0;
        flush_pend_q <= 1'b0;
      end else begin
        if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
        if (accept) begin
          for (int i = 0; i < array_size; i++) acc_q[i] <= merged[i];
          beat_cnt_q <= beat_cnt_q + 4'd1;
        end
        // A blocked flush with data to emit waits for the slot to free.
        flush_pend_q <= flush_req && have_data;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.beat_cnt  = beat_cnt_q;
  assign bus.lane_err  = lane_err_q;

endmodule
